brd_reset_sequencer: RTL

//  Board-level reset sequencer between pad inputs and the system block. Synchronises and debounces
//  the reset pushbutton and the PLL lock flag, then sequences the Ethernet PHY reset pulse before

---
 rtl/brd_reset_sequencer_if.sv | 26 ++
 rtl/brd_reset_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/brd_reset_sequencer_if.sv
// Pad-side and system-side signals of the board reset sequencer, bundled for port connection.
// Latency: none, wires only.
// Backpressure: none; level signals with no handshake.
interface brd_reset_sequencer_if;
   logic       i_reset_n;
   logic       i_pll_locked;
   logic       i_soft_rst;
   logic       o_sys_rst;
   logic       o_phy_reset_n;
   logic       o_ready;
   logic [1:0] o_cause;
   logic [7:0] o_rst_count;
   logic [1:0] o_state;

   // Board side: drives the pad/request inputs, observes the reset outputs.
   modport master (
      output i_reset_n, i_pll_locked, i_soft_rst,
      input  o_sys_rst, o_phy_reset_n, o_ready, o_cause, o_rst_count, o_state
   );

   // Sequencer side.
   modport slave (
      input  i_reset_n, i_pll_locked, i_soft_rst,
      output o_sys_rst, o_phy_reset_n, o_ready, o_cause, o_rst_count, o_state
   );
endinterface

// File: rtl/brd_reset_sequencer.sv
// Board reset sequencer: sync/debounce pads, pulse PHY reset, then release system reset.
// Latency: pad changes reach the FSM after SYNC_STAGES (+DEBOUNCE_CYCLES for the button) edges.
// Backpressure: none; all outputs are registered levels decoded from the next state.
module brd_reset_sequencer #(
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter int HOLD_MIN_CYCLES   = 16,
   parameter int PHY_RST_CYCLES    = 500000,
   parameter int PHY_SETTLE_CYCLES = 50000
) (
   input  logic                  i_brd_clk,
   input  logic                  i_brd_rst,
   brd_reset_sequencer_if.slave  io_seq
);

   localparam int MAX_AB = (DEBOUNCE_CYCLES > HOLD_MIN_CYCLES) ? DEBOUNCE_CYCLES : HOLD_MIN_CYCLES;
   localparam int MAX_CD = (PHY_RST_CYCLES > PHY_SETTLE_CYCLES) ? PHY_RST_CYCLES : PHY_SETTLE_CYCLES;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W  = $clog2(MAX_P + 1);

   localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_HOLD_MIN   = CNT_W'(HOLD_MIN_CYCLES);
   localparam logic [CNT_W-1:0] C_PHY_LAST   = CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(PHY_SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_HOLD       = 2'd0,
      S_PHY_RST    = 2'd1,
      S_PHY_SETTLE = 2'd2,
      S_RUN        = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_btn_sync;
   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic                   w_btn_s;
   logic                   w_lock_s;
   logic                   r_btn_db;
   logic [CNT_W-1:0]       r_db_cnt;
   state_t                 r_state;
   state_t                 w_next;
   logic [CNT_W-1:0]       r_cnt;
   logic                   w_abort;
   logic                   w_run_exit;
   logic [1:0]             w_cause_new;
   logic                   r_sys_rst;
   logic                   r_phy_reset_n;
   logic                   r_ready;
   logic [1:0]             r_cause;
   logic [7:0]             r_rst_count;

   assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];
   assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

   // Synchronise both asynchronous pads into the board clock domain.
   always_ff @(posedge i_brd_clk) begin
      if (i_brd_rst) begin
         r_btn_sync  <= '0;
         r_lock_sync <= '0;
      end else begin
         r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], io_seq.i_reset_n};
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], io_seq.i_pll_locked};
      end
   end

   // Debounce: the level flips only after an unbroken run of mismatching samples.
   always_ff @(posedge i_brd_clk) begin
      if (i_brd_rst) begin
         r_btn_db <= 1'b0;
         r_db_cnt <= '0;
      end else if (w_btn_s != r_btn_db) begin
         if (r_db_cnt == C_DB_LAST) begin
            r_btn_db <= w_btn_s;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + C_ONE;
         end
      end else begin
         r_db_cnt <= '0;
      end
   end

   // Next-state decode; an abort overrides any normal transition in the same cycle.
   always_comb begin
      w_next      = r_state;
      w_abort     = 1'b0;
      w_run_exit  = 1'b0;
      w_cause_new = 2'd3;
      case (r_state)
         S_HOLD:       if (r_cnt >= C_HOLD_MIN && r_btn_db && w_lock_s) w_next = S_PHY_RST;
         S_PHY_RST:    if (r_cnt == C_PHY_LAST)    w_next = S_PHY_SETTLE;
         S_PHY_SETTLE: if (r_cnt == C_SETTLE_LAST) w_next = S_RUN;
         default:      w_next = r_state;
      endcase
      if (r_state != S_HOLD) begin
         w_abort = !r_btn_db || !w_lock_s || io_seq.i_soft_rst;
      end
      if (w_abort) begin
         w_next     = S_HOLD;
         w_run_exit = (r_state == S_RUN);
      end
      // Cause priority: button, then lock loss, then soft request.
      if (!r_btn_db) begin
         w_cause_new = 2'd1;
      end else if (!w_lock_s) begin
         w_cause_new = 2'd2;
      end
   end

   // Time-in-state counter: clears on every state change, stops at HOLD_MIN in S_HOLD.
   always_ff @(posedge i_brd_clk) begin
      if (i_brd_rst) begin
         r_cnt <= '0;
      end else if (w_next != r_state) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_HOLD:       if (r_cnt < C_HOLD_MIN) r_cnt <= r_cnt + C_ONE;
            S_PHY_RST,
            S_PHY_SETTLE: r_cnt <= r_cnt + C_ONE;
            default:      r_cnt <= r_cnt;
         endcase
      end
   end

   // State register plus outputs decoded from the next state, so all change together.
   always_ff @(posedge i_brd_clk) begin
      if (i_brd_rst) begin
         r_state       <= S_HOLD;
         r_sys_rst     <= 1'b1;
         r_phy_reset_n <= 1'b0;
         r_ready       <= 1'b0;
         r_cause       <= 2'd0;
         r_rst_count   <= 8'd0;
      end else begin
         r_state       <= w_next;
         r_sys_rst     <= (w_next != S_RUN);
         r_phy_reset_n <= (w_next == S_PHY_SETTLE) || (w_next == S_RUN);
         r_ready       <= (w_next == S_RUN);
         if (w_run_exit) begin
            r_cause <= w_cause_new;
            if (r_rst_count != 8'hFF) begin
               r_rst_count <= r_rst_count + 8'd1;
            end
         end
      end
   end

   assign io_seq.o_sys_rst     = r_sys_rst;
   assign io_seq.o_phy_reset_n = r_phy_reset_n;
   assign io_seq.o_ready       = r_ready;
   assign io_seq.o_cause       = r_cause;
   assign io_seq.o_rst_count   = r_rst_count;
   assign io_seq.o_state       = r_state;

endmodule
